// File: rtl/arith_op_sequencer.sv
// rtl/arith_op_sequencer.sv - operand entry and operation launch controller for the arithmetic front panel
//
// Debounces N_OPS operation buttons. The first press captures operand A and
// selects the operation. Pressing the same button again captures operand B and
// launches the external arithmetic unit. The result is then held on the LEDs.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   sw         operand switches, sampled on capture; shown on leds while idle
//   btn        raw asynchronous operation buttons
//   op_sel     one-hot selected operation
//   op_a/op_b  captured operands
//   op_start   one-cycle launch pulse, high in the first BUSY cycle
//   op_done    completion from the arithmetic unit, sampled only in BUSY
//   op_result  result from the arithmetic unit, valid with op_done
//   leds       registered display value
//   phase      state: 0 IDLE, 1 WAIT_B, 2 BUSY, 3 SHOW
//   err        sticky timeout flag, cleared on the next A capture
module arith_op_sequencer #(
    parameter int WIDTH           = 16,
    parameter int N_OPS           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [N_OPS-1:0] btn,
    output logic [N_OPS-1:0] op_sel,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_start,
    input  logic             op_done,
    input  logic [WIDTH-1:0] op_result,
    output logic [WIDTH-1:0] leds,
    output logic [1:0]       phase,
    output logic             err
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        BUSY   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t state;

    logic [N_OPS-1:0] btn_s1;
    logic [N_OPS-1:0] btn_s2;
    logic [N_OPS-1:0] stable;
    logic [N_OPS-1:0] pulse;
    logic [CW-1:0]    db_cnt [N_OPS];

    logic [N_OPS-1:0] pick;
    logic             hit;
    logic [TW-1:0]    tcnt;
    logic [WIDTH-1:0] result;

    // Two-flop synchroniser followed by a per-button stability filter.
    // The counter only runs while the synced level disagrees with the
    // accepted level, so any glitch shorter than the window restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            stable <= '0;
            pulse  <= '0;
            for (int i = 0; i < N_OPS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            for (int i = 0; i < N_OPS; i++) begin
                pulse[i] <= 1'b0;
                if (btn_s2[i] != stable[i]) begin
                    if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        stable[i] <= btn_s2[i];
                        db_cnt[i] <= '0;
                        // Only presses produce an event; releases are silent.
                        pulse[i]  <= btn_s2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Lowest-index pulse wins; the losers are simply dropped.
    always_comb begin
        pick = '0;
        hit  = 1'b0;
        for (int i = N_OPS - 1; i >= 0; i--) begin
            if (pulse[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
                hit     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_sel   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_start <= 1'b0;
            leds     <= '0;
            err      <= 1'b0;
            tcnt     <= '0;
            result   <= '0;
        end else begin
            op_start <= 1'b0;
            case (state)
                IDLE, SHOW: begin
                    leds <= (state == IDLE) ? sw : result;
                    if (hit) begin
                        op_a   <= sw;
                        op_sel <= pick;
                        err    <= 1'b0;
                        state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    leds <= op_a;
                    if (hit) begin
                        if (pick == op_sel) begin
                            op_b     <= sw;
                            tcnt     <= '0;
                            op_start <= 1'b1;
                            state    <= BUSY;
                        end else begin
                            op_sel <= pick;
                        end
                    end
                end
                BUSY: begin
                    // op_done is checked before the timeout so a completion
                    // on the final allowed cycle is still accepted cleanly.
                    if (op_done) begin
                        result <= op_result;
                        state  <= SHOW;
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= SHOW;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign phase = state;

endmodule
